// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing from a divided pixel-clock level (in: Clk, Rst, PixClkIn; out: PixTick, HSync, VSync, Active, PixX, PixY, LineStart, FrameStart)
module vga_timing_gen #(
  parameter int H_ACT = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACT = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter logic HS_POL = 1'b0,
  parameter logic VS_POL = 1'b0,
  parameter int CNT_W = 10
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             PixClkIn,
  output logic             PixTick,
  output logic             HSync,
  output logic             VSync,
  output logic             Active,
  output logic [CNT_W-1:0] PixX,
  output logic [CNT_W-1:0] PixY,
  output logic             LineStart,
  output logic             FrameStart
);
  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] H_MAX = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_MAX = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS = CNT_W'(H_ACT);
  localparam logic [CNT_W-1:0] V_VIS = CNT_W'(V_ACT);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACT + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACT + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACT + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACT + V_FP + V_SYNC - 1);
  logic pix_prev, tick, h_wrap, v_wrap, act_nxt;
  logic [CNT_W-1:0] h_cnt, v_cnt, h_nxt, v_nxt;
  always_comb begin
    tick = PixClkIn & ~pix_prev;
    h_wrap = h_cnt == H_MAX;
    v_wrap = v_cnt == V_MAX;
    h_nxt = tick ? (h_wrap ? '0 : h_cnt + CNT_W'(1)) : h_cnt;
    v_nxt = tick && h_wrap ? (v_wrap ? '0 : v_cnt + CNT_W'(1)) : v_cnt;
    act_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
  end
  // pix_prev tracks the input even in reset so no stale edge fires on release
  always_ff @(posedge Clk) begin
    pix_prev <= PixClkIn;
    if (Rst) begin
      h_cnt <= H_MAX;
      v_cnt <= V_MAX;
      PixTick <= 1'b0;
      LineStart <= 1'b0;
      FrameStart <= 1'b0;
      HSync <= ~HS_POL;
      VSync <= ~VS_POL;
      Active <= 1'b0;
      PixX <= '0;
      PixY <= '0;
    end else begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      PixTick <= tick;
      LineStart <= tick && h_nxt == '0;
      FrameStart <= tick && h_nxt == '0 && v_nxt == '0;
      HSync <= (h_nxt >= HS_BEG && h_nxt <= HS_END) ? HS_POL : ~HS_POL;
      VSync <= (v_nxt >= VS_BEG && v_nxt <= VS_END) ? VS_POL : ~VS_POL;
      Active <= act_nxt;
      PixX <= act_nxt ? h_nxt : '0;
      PixY <= act_nxt ? v_nxt : '0;
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of vga_timing_gen at full VGA and at a tiny raster
module tb_vga_timing_gen;
  logic Clk = 1'b0, Rst = 1'b1, pix = 1'b0;
  logic a_tick, a_hs, a_vs, a_act, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  logic b_tick, b_hs, b_vs, b_act, b_ls, b_fs;
  logic [3:0] b_x, b_y;
  logic [25:0] a_vec, b_vec;
  int n_chk = 0, n_fail = 0;
  int ah, av, bh, bv, hs_lo, ls_n, fs_n, vs_lo;
  typedef struct {
    logic rst;
    logic pix;
    logic [25:0] exp;
  } vec_t;
  vec_t vt[12];
  always #5 Clk = ~Clk;
  vga_timing_gen dut_a (
    .Clk(Clk), .Rst(Rst), .PixClkIn(pix), .PixTick(a_tick), .HSync(a_hs), .VSync(a_vs),
    .Active(a_act), .PixX(a_x), .PixY(a_y), .LineStart(a_ls), .FrameStart(a_fs)
  );
  vga_timing_gen #(
    .H_ACT(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACT(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .CNT_W(4)
  ) dut_b (
    .Clk(Clk), .Rst(Rst), .PixClkIn(pix), .PixTick(b_tick), .HSync(b_hs), .VSync(b_vs),
    .Active(b_act), .PixX(b_x), .PixY(b_y), .LineStart(b_ls), .FrameStart(b_fs)
  );
  assign a_vec = {a_tick, a_ls, a_fs, a_act, a_hs, a_vs, a_x, a_y};
  assign b_vec = 26'({b_tick, b_ls, b_fs, b_act, b_hs, b_vs, b_x, b_y});
  function automatic logic [25:0] ea(logic t, ls, fs, act, hs, vs, int x, int y);
    return {t, ls, fs, act, hs, vs, 10'(x), 10'(y)};
  endfunction
  function automatic logic [25:0] pos_a(int h, int v, logic t);
    logic act;
    act = h < 640 && v < 480;
    return ea(t, t && h == 0, t && h == 0 && v == 0, act, !(h >= 656 && h <= 751),
              !(v >= 490 && v <= 491), act ? h : 0, act ? v : 0);
  endfunction
  function automatic logic [25:0] pos_b(int h, int v, logic t);
    logic act;
    act = h < 4 && v < 3;
    return 26'({t, t && h == 0, t && h == 0 && v == 0, act, !(h >= 5 && h <= 6), v != 4,
                4'(act ? h : 0), 4'(act ? v : 0)});
  endfunction
  task automatic chk(input string nm, input logic [25:0] got, input logic [25:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  task automatic drive(input logic r, input logic p);
    Rst = r;
    pix = p;
    @(posedge Clk);
    #1;
  endtask
  task automatic chk_both(input string nm, input logic t);
    chk($sformatf("%s_a h=%0d v=%0d", nm, ah, av), a_vec, pos_a(ah, av, t));
    chk($sformatf("%s_b h=%0d v=%0d", nm, bh, bv), b_vec, pos_b(bh, bv, t));
  endtask
  task automatic tk();
    drive(1'b0, 1'b0);
    chk_both("low", 1'b0);
    ah = ah == 799 ? 0 : ah + 1;
    if (ah == 0) av = av == 524 ? 0 : av + 1;
    bh = bh == 7 ? 0 : bh + 1;
    if (bh == 0) bv = bv == 5 ? 0 : bv + 1;
    drive(1'b0, 1'b1);
    chk_both("tick", 1'b1);
    hs_lo += int'(!a_hs);
    ls_n += int'(a_ls);
    fs_n += int'(b_fs);
    vs_lo += int'(!b_vs);
  endtask
  initial begin
    logic [25:0] rv, rb;
    rv = ea(0, 0, 0, 0, 1, 1, 0, 0);
    rb = 26'(14'b00001100000000);
    vt[0] = '{1'b1, 1'b1, rv};
    vt[1] = '{1'b1, 1'b0, rv};
    vt[2] = '{1'b1, 1'b1, rv};
    vt[3] = '{1'b0, 1'b1, rv};
    vt[4] = '{1'b0, 1'b0, rv};
    vt[5] = '{1'b0, 1'b0, rv};
    vt[6] = '{1'b0, 1'b1, ea(1, 1, 1, 1, 1, 1, 0, 0)};
    vt[7] = '{1'b0, 1'b1, ea(0, 0, 0, 1, 1, 1, 0, 0)};
    vt[8] = '{1'b0, 1'b0, ea(0, 0, 0, 1, 1, 1, 0, 0)};
    vt[9] = '{1'b0, 1'b0, ea(0, 0, 0, 1, 1, 1, 0, 0)};
    vt[10] = '{1'b0, 1'b1, ea(1, 0, 0, 1, 1, 1, 1, 0)};
    vt[11] = '{1'b0, 1'b1, ea(0, 0, 0, 1, 1, 1, 1, 0)};
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].rst, vt[i].pix);
      chk($sformatf("vec%0d", i), a_vec, vt[i].exp);
      if (i < 3) chk($sformatf("vec%0d_b_reset", i), b_vec, rb);
    end
    ah = 1; av = 0; bh = 1; bv = 0;
    hs_lo = 0; ls_n = 0;
    repeat (1598) tk();
    chk("hsync_low_ticks", 26'(hs_lo), 26'(192));
    chk("linestart_count", 26'(ls_n), 26'(1));
    repeat (101) tk();
    chk("stall_pre_x", 26'(a_x), 26'(100));
    repeat (50) begin
      drive(1'b0, 1'b1);
      chk_both("stall_high", 1'b0);
    end
    tk();
    chk("stall_resume_x", 26'(a_x), 26'(101));
    repeat (20) begin
      drive(1'b0, 1'b0);
      chk_both("stuck_low", 1'b0);
    end
    tk();
    repeat (598) tk();
    chk("pre_rst_x", 26'(ah), 26'(700));
    drive(1'b0, 1'b0);
    chk_both("pre_rst_low", 1'b0);
    drive(1'b1, 1'b1);
    chk("rst_mid_a", a_vec, rv);
    chk("rst_mid_b", b_vec, rb);
    ah = 799; av = 524; bh = 7; bv = 5;
    tk();
    chk("rst_frame_start", 26'({a_fs, a_ls, b_fs}), 26'(3'b111));
    fs_n = 0; vs_lo = 0;
    repeat (96) tk();
    chk("b_framestart_count", 26'(fs_n), 26'(2));
    chk("b_vsync_low_ticks", 26'(vs_lo), 26'(16));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
